// File: rtl/rv32i_pkg.sv
// Shared rv32i core constants and types used by the register file.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // x0 is hard-wired; no write to it may ever land in storage.
  function automatic logic is_x0(input reg_addr_t addr);
    return (addr == '0);
  endfunction

endpackage : rv32i_pkg

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: x0 masking plus, with
// REGFILE_BYPASS_EN defined, write-through forwarding of the in-flight write.
module regfile_read_port
  import rv32i_pkg::*;
#(
  parameter int XLEN  = rv32i_pkg::XLEN,
  parameter int NREGS = rv32i_pkg::NREGS
) (
  input  logic                       rst,
  input  logic [REG_ADDR_W-1:0]      rd_addr,
  input  logic [NREGS-1:1][XLEN-1:0] regs,
  input  logic                       wr_en,
  input  logic [REG_ADDR_W-1:0]      wr_addr,
  input  logic [XLEN-1:0]            wr_data,
  output logic [XLEN-1:0]            rd_data
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    rd_data = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (rd_addr == REG_ADDR_W'(i)) rd_data = regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset because that write will not commit.
    if (rst && wr_en && !is_x0(wr_addr) && (wr_addr == rd_addr)) rd_data = wr_data;
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{rst, wr_en, wr_addr, wr_data};
`endif

endmodule : regfile_read_port

// File: rtl/register_file.sv
// rv32i integer register file: x1..x31 in flops, x0 constant zero, two read ports.
// Optional same-cycle write-through on the read ports with macro REGFILE_BYPASS_EN.
module register_file
  import rv32i_pkg::*;
#(
  parameter int XLEN  = rv32i_pkg::XLEN,
  parameter int NREGS = rv32i_pkg::NREGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data
);

  logic [NREGS-1:1][XLEN-1:0] regs_q;
  logic [NREGS-1:1][XLEN-1:0] regs_d;

  // NOTE: the array is reset on purpose: every register must read 0 after reset, so it is flops, not a RAM macro.
  always_comb begin
    regs_d = regs_q;
    if (!rst) begin
      regs_d = '0;
    end else if (wr_en) begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_addr == REG_ADDR_W'(i)) regs_d[i] = wr_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops sample the pre-edge values.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  regfile_read_port #(
    .XLEN (XLEN),
    .NREGS(NREGS)
  ) u_rs1_port (
    .rst    (rst),
    .rd_addr(rs1_addr),
    .regs   (regs_q),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_data(rs1_data)
  );

  regfile_read_port #(
    .XLEN (XLEN),
    .NREGS(NREGS)
  ) u_rs2_port (
    .rst    (rst),
    .rd_addr(rs2_addr),
    .regs   (regs_q),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_data(rs2_data)
  );

endmodule : register_file

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: data width of each register and port.
REQ-002 The block SHALL have parameter NREGS, default 32: number of architectural registers, addressed by 5-bit indices.
REQ-003 The block SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-005 The block SHALL have port wr_en, input, 1: write-back enable, driven from the MEM/WB register write-enable output.
REQ-006 The block SHALL have port wr_addr, input, 5: destination register index, driven from the MEM/WB rd output.
REQ-007 The block SHALL have port wr_data, input, XLEN: write-back data, driven from the MEM/WB data output.
REQ-008 The block SHALL have port rs1_addr, input, 5: read port 1 index.
REQ-009 The block SHALL have port rs2_addr, input, 5: read port 2 index.
REQ-010 The block SHALL have port rs1_data, output, XLEN: read port 1 data.
REQ-011 The block SHALL have port rs2_data, output, XLEN: read port 2 data.

Function
REQ-012 The block SHALL hold registers x1..x31 as XLEN-bit flops and SHALL implement x0 as constant zero with no storage.
REQ-013 The block SHALL write wr_data into register wr_addr on the rising clk edge when rst=1, wr_en=1 and wr_addr!=0.
REQ-014 The block SHALL ignore any write with wr_addr=0, and x0 SHALL read 0 on both ports at all times.
REQ-015 Read ports SHALL be combinational from the address to the data output, with zero-cycle latency relative to the stored array.
REQ-016 Both read ports SHALL be independent, and rs1_addr=rs2_addr SHALL return identical data on both ports.
REQ-017 A write SHALL alter only the addressed register; all other registers SHALL retain their values.
REQ-018 When wr_en=0, the array SHALL remain unchanged regardless of wr_addr and wr_data.
REQ-019 A read of register N in the cycle after its write SHALL return the new value.

Reset
REQ-020 While rst=0 at a rising clk edge, x1..x31 SHALL clear to 0, and any simultaneous write SHALL be discarded.
REQ-021 After reset, rs1_data and rs2_data SHALL read 0 for every address until the first committed write.
REQ-022 Reset asserted in the same cycle as an outstanding write SHALL take priority; the write SHALL NOT commit.

Configuration
REQ-023 With macro REGFILE_BYPASS_EN defined, each read port SHALL be write-through: if rst=1, wr_en=1, wr_addr!=0 and the read address equals wr_addr, the port SHALL output wr_data in the same cycle.
REQ-024 With REGFILE_BYPASS_EN defined, the bypass SHALL be disabled while rst=0, and x0 SHALL still read 0.
REQ-025 Without REGFILE_BYPASS_EN, read ports SHALL return only the stored array value, so a same-cycle read of a register being written SHALL return the old value.

Structure
REQ-026 XLEN, NREGS and REG_ADDR_W=5 SHALL be defined as constants in the shared rv32i package and used by this block.
REQ-027 Read-port logic (x0 masking plus the optional bypass mux) SHALL be one sub-module, regfile_read_port, instantiated twice.

Verification
REQ-028 The bench SHALL check: rst=0 for one edge, then read all 32 addresses on both ports -> all 0.
REQ-029 The bench SHALL check: write x5=0xDEADBEEF, then read rs1=5 and rs2=5 the next cycle -> both 0xDEADBEEF.
REQ-030 The bench SHALL check: write x0=0xFFFFFFFF with wr_en=1, then read rs1=0 -> 0x00000000.
REQ-031 The bench SHALL check: write x7=0x12345678, then in the next cycle write x7=0xCAFEF00D while reading rs2=7 -> 0xCAFEF00D with REGFILE_BYPASS_EN, 0x12345678 without; both builds read 0xCAFEF00D the following cycle.
REQ-032 The bench SHALL check: rst=0 coincident with a write of x3=0x1 -> next-cycle read of x3 returns 0, and the bypass does not forward 0x1 during the reset cycle.
REQ-033 The bench SHALL check: wr_en=0 with wr_addr=9 and wr_data=0xAAAA5555 -> x9 unchanged; a randomized sweep checked against a reference model shows no aliasing across x1..x31.
